// File: rtl/inv_mixcolumns_column.sv
// Inverse MixColumns for one AES state column. Streams the four column bytes
// through the shared 9/B and D/E product ROMs and XOR-accumulates the result.
module inv_mixcolumns_column #(
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] din,
  output logic [7:0]  rom_add,
  output logic        rom_en,
  input  logic [15:0] rom9b_dout,
  input  logic [15:0] romde_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // First capture cycle and final cycle of the RUN phase.
  localparam logic [2:0] CntFirstCap = 3'(ROM_LATENCY);
  localparam logic [2:0] CntLast     = 3'(3 + ROM_LATENCY);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] col_q;
  logic [31:0] acc_q;

  logic        issue;
  logic        capture;
  logic [1:0]  cap_idx;
  logic [7:0]  m9, mb, md, me;
  logic [31:0] term;
  logic [31:0] acc_next;

  assign in_ready = (state_q == StIdle);
  assign m9 = rom9b_dout[15:8];
  assign mb = rom9b_dout[7:0];
  assign md = romde_dout[15:8];
  assign me = romde_dout[7:0];

  // Issue phase: present byte a_cnt to the ROMs during cnt = 0..3.
  always_comb begin
    issue   = (state_q == StRun) && (cnt_q < 3'd4);
    rom_en  = issue;
    rom_add = 8'h00;
    if (issue) begin
      unique case (cnt_q[1:0])
        2'd0:    rom_add = col_q[31:24];
        2'd1:    rom_add = col_q[23:16];
        2'd2:    rom_add = col_q[15:8];
        default: rom_add = col_q[7:0];
      endcase
    end
  end

  // Capture phase: ROM data for byte k arrives at cnt = k + ROM_LATENCY and is
  // rotated into the output rows by the inverse MixColumns coefficient matrix.
  always_comb begin
    capture  = (state_q == StRun) && (cnt_q >= CntFirstCap);
    // Modulo-4 difference is exact since cnt never exceeds 3 + ROM_LATENCY.
    cap_idx  = cnt_q[1:0] - CntFirstCap[1:0];
    term     = 32'h0;
    unique case (cap_idx)
      2'd0:    term = {me, m9, md, mb};
      2'd1:    term = {mb, me, m9, md};
      2'd2:    term = {md, mb, me, m9};
      default: term = {m9, md, mb, me};
    endcase
    acc_next = capture ? (acc_q ^ term) : acc_q;
  end

  // Control FSM with registered result and handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      col_q     <= 32'h0;
      acc_q     <= 32'h0;
      dout      <= 32'h0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            col_q   <= din;
            acc_q   <= 32'h0;
            cnt_q   <= 3'd0;
            state_q <= StRun;
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 3'd1;
          acc_q <= acc_next;
          if (cnt_q == CntLast) begin
            dout      <= acc_next;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
